// File: rtl/user_flash_pkg.sv
// Shared op codes, flash mode/sequence constants and FSM state for the
// user flash command sequencer.
package user_flash_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_PROG  = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  localparam logic [3:0] MODE_IDLE  = 4'h0;
  localparam logic [3:0] MODE_READ  = 4'h0;
  localparam logic [3:0] MODE_PROG  = 4'h4;
  localparam logic [3:0] MODE_ERASE = 4'h8;

  localparam logic [1:0] SEQ_IDLE   = 2'b00;
  localparam logic [1:0] SEQ_SETUP  = 2'b01;
  localparam logic [1:0] SEQ_ACTIVE = 2'b10;
  localparam logic [1:0] SEQ_HOLD   = 2'b11;

  localparam logic [5:0] ROW_COUNT = 6'd48;

  // Wide enough for the longest pulse (erase, 120000 cycles by default)
  localparam int TIMER_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_HOLD,
    ST_DONE
  } state_e;

  // Flash mode constant driven for a given operation
  function automatic logic [3:0] op_mode(input op_e op);
    case (op)
      OP_PROG:  return MODE_PROG;
      OP_ERASE: return MODE_ERASE;
      OP_READ:  return MODE_READ;
      default:  return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/user_flash_timer.sv
// Loadable down-counter used to time each flash phase. Loaded with N-1 on
// phase entry; zero flags the final cycle of the phase.
module user_flash_timer
  import user_flash_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] value,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt_q;

  // Load wins; otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_q <= '0;
    else if (load)          cnt_q <= load_val;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/user_flash_ctrl.sv
// Command sequencer for the Gowin user flash macro: turns read / program /
// row-erase requests into registered address, mode, sequence and strobe
// waveforms, and returns read data or an error status.
module user_flash_ctrl
  import user_flash_pkg::*;
#(
  parameter int T_SETUP_CYC = 2,
  parameter int T_READ_CYC  = 2,
  parameter int T_PROG_CYC  = 1000,
  parameter int T_ERASE_CYC = 120000,
  parameter int T_HOLD_CYC  = 2
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [5:0]  fl_ra,
  output logic [5:0]  fl_ca,
  output logic [5:0]  fl_pa,
  output logic [3:0]  fl_mode,
  output logic [1:0]  fl_seq,
  output logic [1:0]  fl_rmode,
  output logic [1:0]  fl_wmode,
  output logic [1:0]  fl_rbytesel,
  output logic [1:0]  fl_wbytesel,
  output logic        fl_pw,
  output logic        fl_pe,
  output logic        fl_oe,
  output logic [31:0] fl_din,
  input  logic [31:0] fl_dout
);

  localparam logic [TIMER_W-1:0] LD_SETUP = TIMER_W'(T_SETUP_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_READ  = TIMER_W'(T_READ_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_PROG  = TIMER_W'(T_PROG_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_ERASE = TIMER_W'(T_ERASE_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_HOLD  = TIMER_W'(T_HOLD_CYC - 1);

  state_e state_q, state_d;

  op_e         op_q, op_n;
  logic [11:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n;
  logic        err_q, err_n;

  logic               accept, cmd_bad;
  logic               tmr_load, tmr_zero;
  logic [TIMER_W-1:0] tmr_ld_val, tmr_value;

  logic [5:0]  ra_q, ra_d, ca_q, ca_d, pa_q, pa_d;
  logic [3:0]  mode_q, mode_d;
  logic [1:0]  seq_q, seq_d;
  logic        pw_q, pw_d, pe_q, pe_d, oe_q, oe_d;
  logic [31:0] din_q, din_d;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rdata_q;

  assign accept  = cmd_valid && (state_q == ST_IDLE);
  assign cmd_bad = (cmd_op == OP_RSVD) || (cmd_addr[11:6] >= ROW_COUNT);

  // Command fields as seen by the cycle being entered: the accepting edge
  // needs the incoming values, every later phase the registered ones.
  assign op_n    = accept ? op_e'(cmd_op) : op_q;
  assign addr_n  = accept ? cmd_addr      : addr_q;
  assign wdata_n = accept ? cmd_wdata     : wdata_q;
  assign err_n   = accept ? cmd_bad       : err_q;

  // Capture the command on acceptance so the host may move on
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= op_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      err_q   <= err_n;
    end
  end

  // FSM state register
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: each timed phase ends on the cycle its timer reads zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = cmd_bad ? ST_DONE : ST_SETUP;
      ST_SETUP:  if (tmr_zero) state_d = ST_ACTIVE;
      ST_ACTIVE: if (tmr_zero) state_d = ST_HOLD;
      ST_HOLD:   if (tmr_zero) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Reload the phase timer with N-1 whenever a timed phase is entered
  always_comb begin
    tmr_load   = (state_d != state_q) &&
                 (state_d inside {ST_SETUP, ST_ACTIVE, ST_HOLD});
    tmr_ld_val = '0;
    case (state_d)
      ST_SETUP:  tmr_ld_val = LD_SETUP;
      ST_ACTIVE: case (op_n)
                   OP_READ: tmr_ld_val = LD_READ;
                   OP_PROG: tmr_ld_val = LD_PROG;
                   default: tmr_ld_val = LD_ERASE;
                 endcase
      ST_HOLD:   tmr_ld_val = LD_HOLD;
      default:   tmr_ld_val = '0;
    endcase
  end

  user_flash_timer u_timer (
    .clk      (aclk),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_ld_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // Flash outputs decoded from the next state so they can be registered
  // and change exactly on phase boundaries without glitches.
  always_comb begin
    ra_d   = '0;
    ca_d   = '0;
    pa_d   = '0;
    mode_d = MODE_IDLE;
    seq_d  = SEQ_IDLE;
    pw_d   = 1'b0;
    pe_d   = 1'b0;
    oe_d   = 1'b0;
    din_d  = '0;
    if (state_d inside {ST_SETUP, ST_ACTIVE, ST_HOLD}) begin
      ra_d   = addr_n[11:6];
      // Erase works on whole rows; column is dropped once the pulse starts
      ca_d   = (op_n == OP_ERASE && state_d != ST_SETUP) ? 6'd0 : addr_n[5:0];
      pa_d   = (op_n == OP_PROG) ? addr_n[5:0] : 6'd0;
      mode_d = op_mode(op_n);
      din_d  = (op_n == OP_PROG) ? wdata_n : 32'd0;
    end
    case (state_d)
      ST_SETUP: begin
        seq_d = SEQ_SETUP;
        pw_d  = (op_n == OP_PROG);
      end
      ST_ACTIVE: begin
        seq_d = SEQ_ACTIVE;
        oe_d  = (op_n == OP_READ);
        pe_d  = (op_n == OP_PROG) || (op_n == OP_ERASE);
        pw_d  = (op_n == OP_PROG);
      end
      ST_HOLD: seq_d = SEQ_HOLD;
      default: ;
    endcase
  end

  // Output registers; async reset drops every strobe immediately
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      ra_q        <= '0;
      ca_q        <= '0;
      pa_q        <= '0;
      mode_q      <= MODE_IDLE;
      seq_q       <= SEQ_IDLE;
      pw_q        <= 1'b0;
      pe_q        <= 1'b0;
      oe_q        <= 1'b0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      ra_q        <= ra_d;
      ca_q        <= ca_d;
      pa_q        <= pa_d;
      mode_q      <= mode_d;
      seq_q       <= seq_d;
      pw_q        <= pw_d;
      pe_q        <= pe_d;
      oe_q        <= oe_d;
      din_q       <= din_d;
      rsp_valid_q <= (state_d == ST_DONE);
      rsp_err_q   <= (state_d == ST_DONE) && err_n;
    end
  end

  // Sample read data on the final ACTIVE cycle while fl_oe is still high
  always_ff @(posedge aclk or posedge reset) begin
    if (reset)
      rdata_q <= '0;
    else if (state_q == ST_ACTIVE && op_q == OP_READ && tmr_value == '0)
      rdata_q <= fl_dout;
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rdata_q;
  assign fl_ra       = ra_q;
  assign fl_ca       = ca_q;
  assign fl_pa       = pa_q;
  assign fl_mode     = mode_q;
  assign fl_seq      = seq_q;
  assign fl_pw       = pw_q;
  assign fl_pe       = pe_q;
  assign fl_oe       = oe_q;
  assign fl_din      = din_q;
  assign fl_rmode    = 2'b00;
  assign fl_wmode    = 2'b00;
  assign fl_rbytesel = 2'b00;
  assign fl_wbytesel = 2'b00;

endmodule

// File: doc/user_flash_ctrl.md
# user_flash_ctrl

Command sequencer that drives the `Gowin_User_Flash` wrapper (FLASH96K) as its initiator. It accepts single-word read, word-program and row-erase commands over a valid/ready host port. It generates the address, mode, sequence and strobe timing the flash macro requires, and returns read data or completion status. It sits between the on-chip bus bridge and the flash wrapper, and is the only block that toggles flash strobes.

## Interface

Parameters (all values must be ≥ 1):
- `T_SETUP_CYC`, default 2: cycles of address/mode setup before the strobe.
- `T_READ_CYC`, default 2: cycles `fl_oe` is held before `fl_dout` is sampled.
- `T_PROG_CYC`, default 1000: program pulse length in cycles.
- `T_ERASE_CYC`, default 120000: erase pulse length in cycles.
- `T_HOLD_CYC`, default 2: cycles of address hold after the strobe drops.

Ports (the clock is `aclk`; the reset is `reset`):
- `aclk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 00 read, 01 program, 10 erase row, 11 reserved.
- `cmd_addr` in 12: word address; [11:6] is the row, [5:0] is the column.
- `cmd_wdata` in 32: program data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: read data, held until the next read completes.
- `rsp_err` out 1: qualified by `rsp_valid`.
- `busy` out 1: high whenever the state is not IDLE.
- `fl_ra`, `fl_ca`, `fl_pa` out 6 each: flash row, column and page-latch address.
- `fl_mode` out 4, `fl_seq` out 2: operation mode and phase.
- `fl_rmode`, `fl_wmode`, `fl_rbytesel`, `fl_wbytesel` out 2 each: tied to 2'b00 (32-bit word access).
- `fl_pw`, `fl_pe`, `fl_oe` out 1 each: write latch, program/erase enable, output enable.
- `fl_din` out 32: write data to the flash.
- `fl_dout` in 32: read data from the flash.

## Operation

- FSM states: IDLE → SETUP → ACTIVE → HOLD → DONE → IDLE. A command that fails checks takes IDLE → DONE.
- Accept: a command is accepted on `cmd_valid && cmd_ready`. On acceptance, op, address and data are registered. The host may change its inputs after that edge.
- Checks performed at acceptance:
  - op 11 → error.
  - row ≥ 48 → error.
  - On error, no flash output changes. DONE follows in the next cycle with `rsp_err`=1.
- Per-phase outputs:
  - SETUP: `fl_ra`/`fl_ca` = the registered address. `fl_pa` = column for program, 0 otherwise. `fl_mode` = the op mode constant. `fl_seq`=01. For program, `fl_din` = wdata and `fl_pw`=1.
  - ACTIVE:
    - `fl_seq`=10.
    - Read: `fl_oe`=1; `fl_dout` is captured into `rsp_rdata` on the last ACTIVE edge.
    - Program: `fl_pe`=1 and `fl_pw`=1.
    - Erase: `fl_pe`=1 and the column is ignored (`fl_ca`=0).
  - HOLD: `fl_seq`=11, all strobes 0, address and `fl_din` unchanged.
  - DONE: `rsp_valid`=1 for one cycle. All flash outputs return to idle values the same cycle.
- Idle/reset values:
  - All `fl_*` outputs 0, `fl_mode`=MODE_IDLE, `fl_seq`=00.
  - `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
- Reset mid-operation: all outputs take their reset values asynchronously, including `fl_pe` dropping immediately, and no response is issued. The contents of an interrupted program or erase row are undefined; software must re-erase that row.
- `cmd_valid` while busy is ignored, not queued.

## Timing

- Phase timer: loaded with N−1 on phase entry, the phase ends when it reaches 0. Phase length is exactly N cycles.
- Command accepted at edge k:
  - SETUP occupies cycles k+1 … k+Ts.
  - ACTIVE occupies the next Ta cycles (Ta = READ, PROG or ERASE count).
  - HOLD occupies the next Th cycles.
  - `rsp_valid` is high in cycle k+Ts+Ta+Th+1.
- With defaults, a read gives `rsp_valid` 7 cycles after acceptance.
- A rejected command gives `rsp_valid` at k+1.
- `cmd_ready` returns high the cycle after DONE, so back-to-back commands are spaced by at least one IDLE cycle.
- `fl_pe` high-time equals T_PROG_CYC or T_ERASE_CYC exactly, with no glitch at phase boundaries. All `fl_*` outputs are registered.

## Structure

- `user_flash_pkg` holds:
  - the op codes (OP_READ, OP_PROG, OP_ERASE);
  - the mode constants (MODE_IDLE=4'h0, MODE_READ=4'h0, MODE_PROG=4'h4, MODE_ERASE=4'h8);
  - SEQ_IDLE/SETUP/ACTIVE/HOLD;
  - ROW_COUNT=48;
  - the FSM state enum.
- Sub-module `user_flash_timer`: a loadable down-counter, 17 bits wide (sized for T_ERASE_CYC), with `load`, `value` and `zero` ports.
- The top level instantiates `user_flash_ctrl`, which connects to `Gowin_User_Flash`.

## Test plan

- **Reset:** assert `reset` asynchronously mid-cycle → every output is at its reset value before the next `aclk` edge; `cmd_ready`=1.
- **Read:** op 00, addr 0x041, `fl_dout` model = 0xDEADBEEF.
  - `fl_ra`=1, `fl_ca`=1.
  - `fl_oe` high for exactly 2 cycles.
  - `rsp_valid` at acceptance+7 with `rsp_rdata`=0xDEADBEEF and `rsp_err`=0.
- **Program:** op 01, addr 0x7C5, data 0x12345678, T_PROG_CYC=10.
  - `fl_din` stable for SETUP through HOLD.
  - `fl_pe` high for exactly 10 cycles.
  - `fl_pa`=5.
  - `rsp_valid` at acceptance+15.
- **Erase and range check:**
  - Erase row 47 → `fl_pe` high for T_ERASE_CYC cycles and `fl_ca`=0.
  - Erase row 48 (addr 0xC00) → no strobe; `rsp_valid` with `rsp_err`=1 at acceptance+1.
- **Reset mid-erase:** assert `reset` during ACTIVE → `fl_pe` falls without waiting for an `aclk` edge and no `rsp_valid` is issued. A read after reset completes normally.
- **Busy:** hold `cmd_valid` during a read → exactly one command is accepted. A second command is accepted the cycle after DONE, and the op reserved value 11 returns `rsp_err`=1.
